// File: rtl/line_packer.sv
// Packs a 16-bit scanner pixel stream into 128-bit FIFO words and issues one
// DMA command per line into a ring of line slots, with outstanding-command throttling.
module line_packer #(
  parameter int OUTSTANDING_MAX = 6
) (
  input  logic          CLK,
  input  logic          SRST_N,
  input  logic          ENABLE,
  input  logic [27:0]   BASE_ADR,
  input  logic [27:0]   LINE_STRIDE,
  input  logic [15:0]   NUM_LINES,
  input  logic [15:0]   PIX_DATA,
  input  logic          PIX_VALID,
  input  logic          PIX_LAST,
  output logic [127:0]  FIFO_DATA,
  output logic          FIFO_WR,
  input  logic          FIFO_FULL,
  input  logic          FIFO_AFULL,
  output logic [27:0]   START_ADR,
  output logic [27:0]   BUF_SIZE,
  output logic          START,
  input  logic [15:0]   DONE_CNT,
  output logic [15:0]   LINE_IDX,
  output logic [15:0]   DROP_CNT,
  output logic          OVF
);

  typedef enum logic [2:0] {S_IDLE, S_ACTIVE, S_DROP, S_TRUNC, S_CMD, S_GAP} state_t;

  localparam logic [15:0] OUTS_LIMIT = 16'(OUTSTANDING_MAX);

  state_t         state_q, state_d;
  logic           enable_q, last_pend_q, late_q, late_d;
  logic [2:0]     lane_q;
  logic [127:0]   pack_q, word_cur, fifo_data_q;
  logic           fifo_wr_q, start_q, ovf_q;
  logic [27:0]    words_q, words_base, start_adr_q, buf_size_q;
  logic [27:0]    base_q, stride_q, run_adr_q;
  logic [15:0]    num_q, last_idx, line_idx_q, drop_cnt_q, issued_q;
  logic           en_rise, can_accept, take, word_end, do_wr, ovf_set;
  logic           drop_new, set_pend, post_line;

  assign en_rise    = ENABLE & ~enable_q;
  assign can_accept = ENABLE && !FIFO_AFULL && ((issued_q - DONE_CNT) < OUTS_LIMIT);
  assign words_base = (state_q == S_IDLE) ? '0 : words_q;
  assign word_end   = (lane_q == 3'd7) || PIX_LAST;
  assign do_wr      = take && word_end && !FIFO_FULL;
  assign ovf_set    = take && word_end && FIFO_FULL;
  assign last_idx   = (num_q == '0) ? '0 : num_q - 16'd1;
  // The cycle between the final write and CMD also counts as "line closed".
  assign post_line  = (state_q == S_CMD) || (state_q == S_GAP) || last_pend_q;

  always_comb begin
    word_cur = pack_q;
    word_cur[{lane_q, 4'h0} +: 16] = PIX_DATA;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    take     = 1'b0;
    drop_new = 1'b0;
    set_pend = 1'b0;
    late_d   = 1'b0;
    case (state_q)
      S_IDLE: if (PIX_VALID) begin
        if (can_accept) begin
          take    = 1'b1;
          state_d = S_ACTIVE;
        end else begin
          drop_new = 1'b1;
          if (!PIX_LAST) state_d = S_DROP;
        end
      end
      S_ACTIVE: if (last_pend_q) state_d = S_CMD;
                else take = PIX_VALID;
      S_TRUNC: if (last_pend_q) state_d = S_CMD;
               else if (PIX_VALID && PIX_LAST) begin
                 if (words_q != '0) set_pend = 1'b1;
                 else state_d = S_IDLE;
               end
      S_DROP:  if (PIX_VALID && PIX_LAST) state_d = S_IDLE;
      S_CMD:   state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (take && word_end) begin
      if (FIFO_FULL) begin
        if (!PIX_LAST) state_d = S_TRUNC;
        else if (words_base != '0) begin
          state_d  = S_TRUNC;
          set_pend = 1'b1;
        end else state_d = S_IDLE;
      end else if (PIX_LAST) begin
        set_pend = 1'b1;
      end
    end

    // A line arriving while the previous one is still closing is dropped whole,
    // counted once, and its tail is swallowed in DROP.
    if (post_line) begin
      late_d = late_q;
      if (PIX_VALID) begin
        if (!late_q) drop_new = 1'b1;
        late_d = !PIX_LAST;
      end
      if (state_q == S_GAP) state_d = late_d ? S_DROP : S_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
  always_ff @(posedge CLK) begin
    if (!SRST_N) begin
      state_q     <= S_IDLE;
      enable_q    <= 1'b0;
      last_pend_q <= 1'b0;
      late_q      <= 1'b0;
      lane_q      <= '0;
      pack_q      <= '0;
      fifo_data_q <= '0;
      fifo_wr_q   <= 1'b0;
      start_q     <= 1'b0;
      start_adr_q <= '0;
      buf_size_q  <= '0;
      words_q     <= '0;
      base_q      <= '0;
      stride_q    <= '0;
      num_q       <= '0;
      run_adr_q   <= '0;
      line_idx_q  <= '0;
      drop_cnt_q  <= '0;
      issued_q    <= '0;
      ovf_q       <= 1'b0;
    end else begin
      enable_q    <= ENABLE;
      state_q     <= state_d;
      last_pend_q <= set_pend;
      late_q      <= late_d;
      fifo_wr_q   <= do_wr;
      if (do_wr) fifo_data_q <= word_cur;
      if (take) begin
        lane_q <= word_end ? 3'd0 : lane_q + 3'd1;
        pack_q <= word_end ? '0 : word_cur;
      end
      words_q <= words_base + {27'd0, do_wr};

      start_q <= (state_d == S_CMD);
      if (state_d == S_CMD) begin
        start_adr_q <= run_adr_q;
        buf_size_q  <= words_q;
      end

      if (state_q == S_CMD) begin
        issued_q <= issued_q + 16'd1;
        if (line_idx_q == last_idx) begin
          line_idx_q <= '0;
          run_adr_q  <= base_q;
        end else begin
          line_idx_q <= line_idx_q + 16'd1;
          run_adr_q  <= run_adr_q + stride_q;
        end
      end

      if (en_rise) begin
        base_q     <= BASE_ADR;
        stride_q   <= LINE_STRIDE;
        num_q      <= NUM_LINES;
        line_idx_q <= '0;
        run_adr_q  <= BASE_ADR;
        ovf_q      <= 1'b0;
      end
      if (ovf_set) ovf_q <= 1'b1;
      if (drop_new && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign FIFO_DATA = fifo_data_q;
  assign FIFO_WR   = fifo_wr_q;
  assign START     = start_q;
  assign START_ADR = start_adr_q;
  assign BUF_SIZE  = buf_size_q;
  assign LINE_IDX  = line_idx_q;
  assign DROP_CNT  = drop_cnt_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_line_packer.sv
// Directed bench for line_packer: packing, partial lines, ring wrap, throttle,
// FIFO overflow and mid-line reset, against hand-computed values.
module tb_line_packer;

  logic          CLK = 1'b0;
  logic          SRST_N, ENABLE;
  logic [27:0]   BASE_ADR, LINE_STRIDE;
  logic [15:0]   NUM_LINES, PIX_DATA, DONE_CNT;
  logic          PIX_VALID, PIX_LAST, FIFO_FULL, FIFO_AFULL;
  logic [127:0]  FIFO_DATA;
  logic          FIFO_WR, START, OVF;
  logic [27:0]   START_ADR, BUF_SIZE;
  logic [15:0]   LINE_IDX, DROP_CNT;

  always #5 CLK = ~CLK;

  line_packer #(.OUTSTANDING_MAX(6)) dut (
    .CLK(CLK), .SRST_N(SRST_N), .ENABLE(ENABLE),
    .BASE_ADR(BASE_ADR), .LINE_STRIDE(LINE_STRIDE), .NUM_LINES(NUM_LINES),
    .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID), .PIX_LAST(PIX_LAST),
    .FIFO_DATA(FIFO_DATA), .FIFO_WR(FIFO_WR), .FIFO_FULL(FIFO_FULL), .FIFO_AFULL(FIFO_AFULL),
    .START_ADR(START_ADR), .BUF_SIZE(BUF_SIZE), .START(START),
    .DONE_CNT(DONE_CNT), .LINE_IDX(LINE_IDX), .DROP_CNT(DROP_CNT), .OVF(OVF)
  );

  logic [127:0] wr_q[$];
  logic [27:0]  sa_q[$];
  logic [27:0]  bs_q[$];
  int n_chk = 0;
  int n_bad = 0;
  int w0, s0;

  // Every FIFO_WR cycle and every START cycle is logged once.
  always @(negedge CLK) begin
    if (FIFO_WR) wr_q.push_back(FIFO_DATA);
    if (START) begin
      sa_q.push_back(START_ADR);
      bs_q.push_back(BUF_SIZE);
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_line(input int n, input logic [15:0] first, input int full_lo, input int full_hi);
    for (int i = 0; i < n; i++) begin
      PIX_VALID = 1'b1;
      PIX_DATA  = first + 16'(i);
      PIX_LAST  = (i == n - 1);
      FIFO_FULL = (i >= full_lo) && (i <= full_hi);
      tick();
    end
    PIX_VALID = 1'b0;
    PIX_LAST  = 1'b0;
    FIFO_FULL = 1'b0;
    repeat (8) tick();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wr"},   FIFO_WR, 0);
    check({tag, "_st"},   START, 0);
    check({tag, "_data"}, FIFO_DATA, 0);
    check({tag, "_sa"},   START_ADR, 0);
    check({tag, "_bs"},   BUF_SIZE, 0);
    check({tag, "_idx"},  LINE_IDX, 0);
    check({tag, "_drop"}, DROP_CNT, 0);
    check({tag, "_ovf"},  OVF, 0);
  endtask

  initial begin
    SRST_N = 1'b0; ENABLE = 1'b0;
    BASE_ADR = 28'h100; LINE_STRIDE = 28'h40; NUM_LINES = 16'd2;
    PIX_DATA = '0; PIX_VALID = 1'b0; PIX_LAST = 1'b0;
    FIFO_FULL = 1'b0; FIFO_AFULL = 1'b0; DONE_CNT = '0;
    repeat (3) tick();
    check_zero("rst");
    SRST_N = 1'b1;
    tick();
    ENABLE = 1'b1;
    repeat (2) tick();

    // Full 16-pixel line
    w0 = wr_q.size(); s0 = sa_q.size();
    send_line(16, 16'h0001, -1, -1);
    check("full_nwr", wr_q.size() - w0, 2);
    check("full_w0", wr_q[w0], 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    check("full_w1", wr_q[w0+1], 128'h0010_000f_000e_000d_000c_000b_000a_0009);
    check("full_nst", sa_q.size() - s0, 1);
    check("full_sa", sa_q[s0], 28'h100);
    check("full_bs", bs_q[s0], 28'd2);
    check("full_idx", LINE_IDX, 16'd1);

    // Partial line, upper lanes zero
    w0 = wr_q.size(); s0 = sa_q.size();
    send_line(3, 16'h000A, -1, -1);
    check("part_nwr", wr_q.size() - w0, 1);
    check("part_w", wr_q[w0], 128'h000c_000b_000a);
    check("part_sa", sa_q[s0], 28'h140);
    check("part_bs", bs_q[s0], 28'd1);
    check("part_idx", LINE_IDX, 16'd0);

    // Third line wraps back to the base slot
    s0 = sa_q.size();
    send_line(2, 16'h0055, -1, -1);
    check("wrap_sa", sa_q[s0], 28'h100);
    check("wrap_idx", LINE_IDX, 16'd1);

    // Throttle: fresh reset, DONE_CNT stuck at 0, seven lines
    SRST_N = 1'b0; tick(); SRST_N = 1'b1; repeat (2) tick();
    w0 = wr_q.size(); s0 = sa_q.size();
    for (int l = 0; l < 7; l++) send_line(2, 16'(16'h0300 + 16'(l * 2)), -1, -1);
    check("thr_nst", sa_q.size() - s0, 6);
    check("thr_nwr", wr_q.size() - w0, 6);
    check("thr_drop", DROP_CNT, 16'd1);

    // Overflow on word 3 of a 4-word line, then a normal line
    DONE_CNT = 16'd6;
    tick();
    w0 = wr_q.size(); s0 = sa_q.size();
    send_line(32, 16'h0100, 16, 23);
    check("ovf_nwr", wr_q.size() - w0, 2);
    check("ovf_nst", sa_q.size() - s0, 1);
    check("ovf_bs", bs_q[s0], 28'd2);
    check("ovf_sa", sa_q[s0], 28'h100);
    check("ovf_flag", OVF, 1'b1);
    w0 = wr_q.size(); s0 = sa_q.size();
    send_line(8, 16'h0200, -1, -1);
    check("post_nwr", wr_q.size() - w0, 1);
    check("post_w", wr_q[w0], 128'h0207_0206_0205_0204_0203_0202_0201_0200);
    check("post_bs", bs_q[s0], 28'd1);
    check("post_sa", sa_q[s0], 28'h140);
    check("post_ovf", OVF, 1'b1);
    check("post_drop", DROP_CNT, 16'd1);

    // Reset after 5 pixels of a line
    w0 = wr_q.size(); s0 = sa_q.size();
    for (int i = 0; i < 5; i++) begin
      PIX_VALID = 1'b1; PIX_DATA = 16'(16'h0400 + 16'(i)); PIX_LAST = 1'b0;
      tick();
    end
    PIX_VALID = 1'b0;
    SRST_N = 1'b0;
    tick();
    check_zero("mid");
    SRST_N = 1'b1; DONE_CNT = '0;
    repeat (2) tick();
    check("mid_nwr", wr_q.size() - w0, 0);
    check("mid_nst", sa_q.size() - s0, 0);
    send_line(3, 16'h0021, -1, -1);
    check("rs_nwr", wr_q.size() - w0, 1);
    check("rs_w", wr_q[w0], 128'h0023_0022_0021);
    check("rs_sa", sa_q[s0], 28'h100);
    check("rs_bs", bs_q[s0], 28'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/line_packer.md
LINE_PACKER -- requirements
Module: line_packer

Interface
REQ-001 SHALL have parameter OUTSTANDING_MAX, default 6, meaning the maximum number of DMA commands issued but not yet completed.
REQ-002 SHALL have port CLK, in, 1, the single clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port SRST_N, in, 1, synchronous active-low reset.
REQ-004 SHALL have port ENABLE, in, 1, capture enable.
REQ-005 SHALL have port BASE_ADR, in, 28, ring base address, in 16-byte words.
REQ-006 SHALL have port LINE_STRIDE, in, 28, address step per line slot, in 16-byte words.
REQ-007 SHALL have port NUM_LINES, in, 16, ring slot count; the value 0 is treated as 1.
REQ-008 SHALL have ports PIX_DATA (in, 16), PIX_VALID (in, 1) and PIX_LAST (in, 1), a scanner pixel stream with no backpressure.
REQ-009 SHALL have ports FIFO_DATA (out, 128), FIFO_WR (out, 1), FIFO_FULL (in, 1) and FIFO_AFULL (in, 1), the data FIFO write side feeding the DMA.
REQ-010 SHALL have ports START_ADR (out, 28), BUF_SIZE (out, 28) and START (out, 1), the DMA command outputs.
REQ-011 SHALL have port DONE_CNT, in, 16, the DMA completed-command counter.
REQ-012 SHALL have ports LINE_IDX (out, 16), DROP_CNT (out, 16) and OVF (out, 1), status outputs.

Function
REQ-013 SHALL latch BASE_ADR, LINE_STRIDE and NUM_LINES on the ENABLE rising edge, and on that edge SHALL reset LINE_IDX to 0, the running address to BASE_ADR, and clear OVF.
REQ-014 SHALL implement the states IDLE, ACTIVE, DROP, TRUNC, CMD and GAP.
REQ-015 SHALL, in IDLE on PIX_VALID, enter ACTIVE and use that pixel when ENABLE=1, FIFO_AFULL=0 and (issued_cnt-DONE_CNT) mod 2^16 < OUTSTANDING_MAX; otherwise it SHALL enter DROP and increment DROP_CNT, saturating at 0xFFFF.
REQ-016 SHALL pack pixels little-endian: pixel n of a word occupies bits [16n+15:16n], n=0..7.
REQ-017 SHALL register FIFO_WR high for exactly one cycle, the cycle after the 8th pixel of a word or after the PIX_LAST pixel; on PIX_LAST, unfilled lanes SHALL be zero.
REQ-018 SHALL count words written per line in a 28-bit counter.
REQ-019 SHALL treat FIFO_FULL=1 on a pending write as overflow: discard the word, set OVF (sticky), and enter TRUNC.
REQ-020 SHALL, in TRUNC, discard pixels until PIX_LAST.
REQ-021 SHALL, on PIX_LAST, go from ACTIVE to CMD, and from TRUNC to CMD if words>0, otherwise to IDLE.
REQ-022 SHALL, on PIX_LAST, go from DROP to IDLE.
REQ-023 SHALL, in CMD, drive START=1 for one cycle with BUF_SIZE equal to the words written and START_ADR equal to the running address; CMD SHALL be entered the cycle after the final FIFO_WR.
REQ-024 SHALL hold START_ADR and BUF_SIZE stable from CMD until the next CMD.
REQ-025 SHALL, in CMD, increment issued_cnt (16-bit, wrapping), and advance LINE_IDX and the running address by LINE_STRIDE.
REQ-026 SHALL, when LINE_IDX equals NUM_LINES-1, wrap LINE_IDX to 0 and the running address to BASE_ADR.
REQ-027 SHALL, in GAP, keep START=0 for one cycle and then go to IDLE, guaranteeing a START edge per command.
REQ-028 SHALL discard pixels arriving in CMD or GAP and increment DROP_CNT once per such line.
REQ-029 SHALL NOT abort the current line when ENABLE falls; the line completes normally and no new line is accepted afterwards.
REQ-030 SHALL, when FIFO_FULL and PIX_LAST occur on the same word, treat it as overflow with the word discarded.

Reset
REQ-031 SHALL, on SRST_N=0 at a clock edge, force state IDLE, FIFO_WR=0, START=0, FIFO_DATA=0, START_ADR=0, BUF_SIZE=0, LINE_IDX=0, DROP_CNT=0, OVF=0, issued_cnt=0, lane and word counters 0.
REQ-032 SHALL, on reset mid-line, abandon the line with no FIFO_WR and no START.

Verification
REQ-033 SHALL be verified for a full line: BASE=0x100, STRIDE=0x40, NUM_LINES=2, 16 pixels 0x0001..0x0010 -> 2 FIFO_WR, word0=0x0008_0007_..._0001, START with START_ADR=0x100 and BUF_SIZE=2.
REQ-034 SHALL be verified for a partial line: 3 pixels A,B,C with PIX_LAST -> one word 0x..._0000_000C_000B_000A with upper lanes zero, BUF_SIZE=1.
REQ-035 SHALL be verified for ring wrap: 3 lines with NUM_LINES=2 -> START_ADR 0x100, 0x140, 0x100; LINE_IDX 1, 0, 1.
REQ-036 SHALL be verified for throttle: DONE_CNT held at 0 and 7 lines sent -> 6 STARTs, DROP_CNT=1, no FIFO_WR for line 7.
REQ-037 SHALL be verified for overflow: FIFO_FULL forced on word 3 of a 4-word line -> OVF=1, BUF_SIZE=2, next line accepted normally.
REQ-038 SHALL be verified for reset mid-line: SRST_N low after 5 pixels -> all outputs 0, and the next line starts at lane 0 and BASE_ADR.
